// File: rtl/conv_frame_encoder.sv
// Convolutional frame encoder: one k*L-bit message in, L n-bit code words out,
// using runtime-loaded generator polynomials. Vectors are MSB-first: bit "0" is the MSB.
module conv_frame_encoder #(
   parameter int N = 4,
   parameter int K = 2,
   parameter int M = 4,
   parameter int L = 6,
   localparam int A = $clog2(N)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [A-1:0]     address,
   input  logic [M-1:0]     data,
   input  logic             start,
   input  logic [K*L-1:0]   message,
   input  logic             enable,
   input  logic             restart,
   output logic [N-1:0]     encoded,
   output logic             valid,
   output logic             busy,
   output logic             done,
   output logic [N*L-1:0]   frame,
   output logic             tail_ok
);

   localparam int CW = $clog2(L + 1);

   typedef enum logic [1:0] {S_IDLE, S_ENCODE, S_DONE} state_t;

   state_t           r_state;
   state_t           w_next;
   logic [M-1:0]     r_poly [N];
   logic [K*L-1:0]   r_msg;
   logic [M-K-1:0]   r_st;
   logic [CW-1:0]    r_cnt;
   logic [N-1:0]     r_enc;
   logic             r_valid;
   logic             r_busy;
   logic             r_done;
   logic [N*L-1:0]   r_frame;
   logic             r_tail;

   logic             w_accept;
   logic             w_step;
   logic             w_load;
   logic [K-1:0]     w_slice;
   logic [M-1:0]     w_x;
   logic [N-1:0]     w_code;

   // Slice j is the j-th K-bit group counted from the message MSB.
   always_comb begin
      w_slice = '0;
      for (int j = 0; j < L; j++) begin
         if (r_cnt == CW'(j)) w_slice = r_msg[K*L-1-K*j -: K];
      end
   end

   assign w_x = {w_slice, r_st};

   always_comb begin
      w_code = '0;
      for (int i = 0; i < N; i++) begin
         w_code[N-1-i] = ^(r_poly[i] & w_x);
      end
   end

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      w_step   = 1'b0;
      w_load   = 1'b0;
      if (restart) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (load) begin
                  w_load = (32'(address) < N);
               end else if (start) begin
                  w_accept = 1'b1;
                  w_next   = S_ENCODE;
               end
            end
            S_ENCODE: begin
               if (enable) begin
                  w_step = 1'b1;
                  if (r_cnt == CW'(L - 1)) w_next = S_DONE;
               end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         for (int i = 0; i < N; i++) r_poly[i] <= '0;
         r_msg   <= '0;
         r_st    <= '0;
         r_cnt   <= '0;
         r_enc   <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_frame <= '0;
         r_tail  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_valid <= w_step;
         r_done  <= (r_state == S_DONE) && !restart;
         if (w_load) r_poly[address] <= data;
         if (restart) begin
            r_st    <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_frame <= '0;
         end else if (w_accept) begin
            r_msg   <= message;
            r_st    <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_frame <= '0;
            r_tail  <= (message[M-K-1:0] == '0);
         end else if (w_step) begin
            r_enc <= w_code;
            r_st  <= w_x[M-1 -: M-K];
            r_cnt <= r_cnt + CW'(1);
            for (int j = 0; j < L; j++) begin
               if (r_cnt == CW'(j)) r_frame[N*L-1-N*j -: N] <= w_code;
            end
         end else if (r_state == S_DONE) begin
            r_busy <= 1'b0;
         end
      end
   end

   assign encoded = r_enc;
   assign valid   = r_valid;
   assign busy    = r_busy;
   assign done    = r_done;
   assign frame   = r_frame;
   assign tail_ok = r_tail;

endmodule

// File: tb/tb_conv_frame_encoder.sv
// Self-checking bench for conv_frame_encoder: directed test-plan frames plus
// randomized frames compared against a bit-level model of the encoding rule.
module tb_conv_frame_encoder;

   localparam int N = 4;
   localparam int K = 2;
   localparam int M = 4;
   localparam int L = 6;

   logic          clk = 1'b0;
   logic          reset, load, start, enable, restart;
   logic [1:0]    address;
   logic [3:0]    data;
   logic [11:0]   message;
   logic [3:0]    encoded;
   logic          valid, busy, done, tail_ok;
   logic [23:0]   frame;

   int checks = 0;
   int errors = 0;

   int          pb [N][M];
   logic [3:0]  mw [L];
   logic [23:0] mframe;
   logic        mtail;

   logic [3:0]  got_w [L];
   int          got_cyc [L];
   int          got_n;
   int          done_cyc;
   logic        done_busy;
   logic        done_valid;
   bit          tmo;

   localparam logic [11:0] MSG_BASIC   = 12'b1011_0111_0000;
   localparam logic [23:0] FRAME_BASIC = 24'b1100_1001_1100_0011_1010_0000;
   logic [3:0] exp_basic [L];

   always #5 clk = ~clk;

   conv_frame_encoder #(.N(N), .K(K), .M(M), .L(L)) dut (
      .clk(clk), .reset(reset), .load(load), .address(address), .data(data),
      .start(start), .message(message), .enable(enable), .restart(restart),
      .encoded(encoded), .valid(valid), .busy(busy), .done(done),
      .frame(frame), .tail_ok(tail_ok)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic load_poly(input int a, input logic [3:0] v);
      load = 1'b1; address = a[1:0]; data = v;
      tick();
      load = 1'b0;
      for (int b = 0; b < M; b++) pb[a][b] = int'(v[M-1-b]);
   endtask

   task automatic load_basic;
      load_poly(0, 4'b1001); load_poly(1, 4'b1100);
      load_poly(2, 4'b0110); load_poly(3, 4'b0011);
   endtask

   // Reference: X = {slice, state} read MSB-first, code bit i = parity(poly_i & X).
   task automatic model(input logic [11:0] msg);
      int st [M-K];
      int x [M];
      int par;
      for (int t = 0; t < M-K; t++) st[t] = 0;
      mframe = '0;
      for (int j = 0; j < L; j++) begin
         for (int t = 0; t < K; t++) x[t] = int'(msg[K*L-1-(K*j+t)]);
         for (int t = 0; t < M-K; t++) x[K+t] = st[t];
         for (int i = 0; i < N; i++) begin
            par = 0;
            for (int b = 0; b < M; b++) par = par ^ (pb[i][b] & x[b]);
            mw[j][N-1-i] = par[0];
         end
         for (int t = 0; t < M-K; t++) st[t] = x[t];
         mframe = {mframe[19:0], mw[j]};
      end
      mtail = (msg[1:0] == 2'b00);
   endtask

   // Drives one frame and records words, their cycle offsets and the done cycle.
   task automatic run_frame(input logic [11:0] msg, input int pause_after,
                            input int pause_len, input bit noisy);
      int paused = 0;
      message = msg; start = 1'b1; enable = 1'b1;
      tick();
      start = 1'b0;
      got_n = 0; done_cyc = -1; tmo = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         enable = !(got_n == pause_after && paused < pause_len);
         if (!enable) paused++;
         if (noisy) begin
            start = 1'b1; message = ~msg;
            load = 1'b1; address = 2'd2; data = 4'hF;
         end
         tick();
         if (valid) begin
            if (got_n < L) begin
               got_w[got_n] = encoded; got_cyc[got_n] = c;
            end
            got_n++;
         end
         if (done) begin
            done_cyc = c; done_busy = busy; done_valid = valid; tmo = 1'b0;
            break;
         end
      end
      start = 1'b0; load = 1'b0; enable = 1'b1; message = msg;
   endtask

   task automatic test_reset;
      reset = 1'b0; load = 1'b0; start = 1'b0; enable = 1'b0; restart = 1'b0;
      address = '0; data = '0; message = '0;
      tick(); tick();
      checks++;
      if ({encoded, valid, busy, done, frame, tail_ok} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got enc=%b v=%b b=%b d=%b f=%h t=%b want all 0",
                  encoded, valid, busy, done, frame, tail_ok);
      end
      #3 reset = 1'b1;
      tick();
   endtask

   task automatic test_basic;
      load_basic();
      run_frame(MSG_BASIC, -1, 0, 1'b0);
      checks++;
      if (tmo !== 1'b0 || got_n !== L) begin
         errors++; $display("FAIL basic_count: got %0d words timeout=%0d want %0d", got_n, tmo, L);
      end
      for (int j = 0; j < L; j++) begin
         checks++;
         if (got_w[j] !== exp_basic[j] || got_cyc[j] !== j + 1) begin
            errors++;
            $display("FAIL basic_word%0d: got %b at cycle %0d want %b at cycle %0d",
                     j, got_w[j], got_cyc[j], exp_basic[j], j + 1);
         end
      end
      checks++;
      if (done_cyc !== 7 || done_busy !== 1'b0 || done_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_done: got cycle %0d busy=%b valid=%b want cycle 7 busy=0 valid=0",
                  done_cyc, done_busy, done_valid);
      end
      checks++;
      if (frame !== FRAME_BASIC || tail_ok !== 1'b1) begin
         errors++; $display("FAIL basic_frame: got %b tail=%b want %b tail=1", frame, tail_ok, FRAME_BASIC);
      end
      tick();
      checks++;
      if (done !== 1'b0 || frame !== FRAME_BASIC) begin
         errors++; $display("FAIL basic_after: got done=%b frame=%h want done=0 frame=%h", done, frame, FRAME_BASIC);
      end
   endtask

   task automatic test_pause;
      run_frame(MSG_BASIC, 2, 2, 1'b0);
      for (int j = 0; j < L; j++) begin
         checks++;
         if (got_w[j] !== exp_basic[j] || got_cyc[j] !== (j < 2 ? j + 1 : j + 3)) begin
            errors++;
            $display("FAIL pause_word%0d: got %b at cycle %0d want %b at cycle %0d",
                     j, got_w[j], got_cyc[j], exp_basic[j], (j < 2 ? j + 1 : j + 3));
         end
      end
      checks++;
      if (tmo !== 1'b0 || done_cyc !== 9 || got_n !== L || frame !== FRAME_BASIC) begin
         errors++;
         $display("FAIL pause_done: got cycle %0d words %0d frame %h want cycle 9 words 6 frame %h",
                  done_cyc, got_n, frame, FRAME_BASIC);
      end
      tick();
   endtask

   task automatic test_tail;
      model(12'b0100_0100_0001);
      run_frame(12'b0100_0100_0001, -1, 0, 1'b0);
      checks++;
      if (tmo !== 1'b0 || got_n !== L || tail_ok !== 1'b0 || frame !== mframe) begin
         errors++;
         $display("FAIL tail_frame: got words %0d tail=%b frame=%h want words 6 tail=0 frame=%h",
                  got_n, tail_ok, frame, mframe);
      end
      tick();
   endtask

   task automatic test_restart;
      int n = 0;
      message = MSG_BASIC; start = 1'b1; enable = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 20 && n < 3; c++) begin
         tick();
         if (valid) n++;
      end
      restart = 1'b1;
      tick();
      restart = 1'b0;
      checks++;
      if (n !== 3 || valid !== 1'b0 || busy !== 1'b0 || frame !== '0 || done !== 1'b0) begin
         errors++;
         $display("FAIL restart_clear: got words %0d v=%b b=%b d=%b f=%h want 3 words, all 0",
                  n, valid, busy, done, frame);
      end
      model(12'b0101_1100_0000);
      run_frame(12'b0101_1100_0000, -1, 0, 1'b0);
      checks++;
      if (tmo !== 1'b0 || got_n !== L || frame !== mframe || tail_ok !== mtail) begin
         errors++;
         $display("FAIL restart_next: got words %0d frame=%h tail=%b want 6 frame=%h tail=%b",
                  got_n, frame, tail_ok, mframe, mtail);
      end
      tick();
   endtask

   task automatic test_load_during_encode;
      run_frame(MSG_BASIC, -1, 0, 1'b1);
      checks++;
      if (tmo !== 1'b0 || got_n !== L || frame !== FRAME_BASIC) begin
         errors++;
         $display("FAIL busy_inputs: got words %0d frame=%h want 6 frame=%h", got_n, frame, FRAME_BASIC);
      end
      tick();
      run_frame(MSG_BASIC, -1, 0, 1'b0);
      checks++;
      if (tmo !== 1'b0 || frame !== FRAME_BASIC) begin
         errors++; $display("FAIL poly_kept: got frame=%h want %h", frame, FRAME_BASIC);
      end
      tick();
   endtask

   task automatic test_async_reset;
      message = MSG_BASIC; start = 1'b1; enable = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({encoded, valid, busy, done, frame, tail_ok} !== '0) begin
         errors++;
         $display("FAIL async_reset: got enc=%b v=%b b=%b d=%b f=%h t=%b want all 0",
                  encoded, valid, busy, done, frame, tail_ok);
      end
      tick();
      #3 reset = 1'b1;
      tick();
      for (int i = 0; i < N; i++) for (int b = 0; b < M; b++) pb[i][b] = 0;
      run_frame(MSG_BASIC, -1, 0, 1'b0);
      checks++;
      if (tmo !== 1'b0 || got_n !== L || frame !== '0 || got_w[0] !== 4'b0000) begin
         errors++; $display("FAIL polys_cleared: got words %0d frame=%h want 6 frame=0", got_n, frame);
      end
      tick();
   endtask

   task automatic test_random;
      logic [11:0] msg;
      int pa, pl;
      bit nz;
      for (int it = 0; it < 8; it++) begin
         for (int i = 0; i < N; i++) load_poly(i, 4'($urandom));
         msg = 12'($urandom);
         if (it == 0) msg[1:0] = 2'b00;
         pa = $urandom_range(0, 5);
         pl = $urandom_range(0, 3);
         nz = 1'($urandom);
         model(msg);
         run_frame(msg, pa, pl, nz);
         for (int j = 0; j < L; j++) begin
            checks++;
            if (got_w[j] !== mw[j] || got_cyc[j] !== (j < pa ? j + 1 : j + 1 + pl)) begin
               errors++;
               $display("FAIL rand%0d_word%0d: got %b at cycle %0d want %b at cycle %0d",
                        it, j, got_w[j], got_cyc[j], mw[j], (j < pa ? j + 1 : j + 1 + pl));
            end
         end
         checks++;
         if (tmo !== 1'b0 || got_n !== L || done_cyc !== 7 + pl || frame !== mframe || tail_ok !== mtail) begin
            errors++;
            $display("FAIL rand%0d_frame: got words %0d done@%0d frame=%h tail=%b want 6 done@%0d frame=%h tail=%b",
                     it, got_n, done_cyc, frame, tail_ok, 7 + pl, mframe, mtail);
         end
         tick();
      end
   endtask

   initial begin
      exp_basic[0] = 4'b1100; exp_basic[1] = 4'b1001; exp_basic[2] = 4'b1100;
      exp_basic[3] = 4'b0011; exp_basic[4] = 4'b1010; exp_basic[5] = 4'b0000;
      for (int i = 0; i < N; i++) for (int b = 0; b < M; b++) pb[i][b] = 0;
      test_reset();
      test_basic();
      test_pause();
      test_tail();
      test_restart();
      test_load_during_encode();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
